// File: rtl/fht_input_loader.sv
// Loads a frame of N = 4*2^A_BIT samples into four banks in bit-reversed order,
// then handshakes with the transform controller and counts completed frames.
module fht_input_loader #(
  parameter int unsigned A_BIT = 8,
  parameter int unsigned D_BIT = 16
) (
  input  logic               iCLK_2,
  input  logic               iRESET,
  input  logic               iCLEAR,
  input  logic               iVALID,
  input  logic [D_BIT-1:0]   iDATA,
  output logic               oREADY,
  input  logic               iFHT_RDY,
  output logic               oSTART,
  output logic [A_BIT-1:0]   oADDR_WR,
  output logic [D_BIT-1:0]   oDATA_WR,
  output logic [3:0]         oWE,
  output logic               oDONE,
  output logic [7:0]         oFRAME_CNT
);

  localparam int unsigned C_BIT = A_BIT + 2;

  typedef enum logic [2:0] {
    StIdle, StLoad, StLast, StStart, StWaitBusy, StWaitDone
  } state_e;

  state_e             state_q, state_d;
  logic [C_BIT-1:0]   cnt_q, cnt_d;
  logic [C_BIT-1:0]   rev;
  logic [3:0]         we_q, we_d;
  logic [A_BIT-1:0]   addr_q, addr_d;
  logic [D_BIT-1:0]   data_q, data_d;
  logic               done_q, done_d;
  logic [7:0]         frame_q, frame_d;
  logic               accept;

  always_comb begin
    for (int i = 0; i < int'(C_BIT); i++) begin
      rev[i] = cnt_q[int'(C_BIT) - 1 - i];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    done_d  = 1'b0;
    frame_d = frame_q;
    if (iCLEAR) begin
      // Abort wins over every transition; the frame count survives.
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (iFHT_RDY) state_d = StLoad;
        end
        StLoad: begin
          if (iVALID) begin
            accept = 1'b1;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == {C_BIT{1'b1}}) state_d = StLast;
          end
        end
        StLast:     state_d = StStart;
        StStart:    state_d = StWaitBusy;
        StWaitBusy: begin
          if (!iFHT_RDY) state_d = StWaitDone;
        end
        StWaitDone: begin
          if (iFHT_RDY) begin
            state_d = StLoad;
            done_d  = 1'b1;
            frame_d = frame_q + 8'd1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Write port: one strobe per accepted sample, address/data held otherwise.
  always_comb begin
    we_d   = '0;
    addr_d = addr_q;
    data_d = data_q;
    if (accept) begin
      we_d[rev[C_BIT-1 -: 2]] = 1'b1;
      addr_d                  = rev[A_BIT-1:0];
      data_d                  = iDATA;
    end
  end

  always_ff @(posedge iCLK_2 or negedge iRESET) begin
    if (!iRESET) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      we_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      done_q  <= done_d;
      frame_q <= frame_d;
    end
  end

  assign oREADY     = (state_q == StLoad);
  assign oSTART     = (state_q == StStart);
  assign oWE        = we_q;
  assign oADDR_WR   = addr_q;
  assign oDATA_WR   = data_q;
  assign oDONE      = done_q;
  assign oFRAME_CNT = frame_q;

endmodule

// File: tb/tb_fht_input_loader.sv
// Directed bench for fht_input_loader: default-size instance for load/handshake/clear,
// plus a 16-sample instance to reach the frame-count wrap quickly.
module tb_fht_input_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear, valid, rdy;
  logic [15:0] data;
  logic        ready, start, done;
  logic [7:0]  addr;
  logic [15:0] wdata;
  logic [3:0]  we;
  logic [7:0]  fcnt;

  logic        s_clear, s_valid, s_rdy;
  logic [15:0] s_data;
  logic        s_ready, s_start, s_done;
  logic [1:0]  s_addr;
  logic [15:0] s_wdata;
  logic [3:0]  s_we;
  logic [7:0]  s_fcnt;

  always #5 clk = ~clk;

  fht_input_loader dut (
    .iCLK_2(clk), .iRESET(rst_n), .iCLEAR(clear), .iVALID(valid), .iDATA(data),
    .oREADY(ready), .iFHT_RDY(rdy), .oSTART(start), .oADDR_WR(addr), .oDATA_WR(wdata),
    .oWE(we), .oDONE(done), .oFRAME_CNT(fcnt)
  );

  fht_input_loader #(.A_BIT(2), .D_BIT(16)) dut_s (
    .iCLK_2(clk), .iRESET(rst_n), .iCLEAR(s_clear), .iVALID(s_valid), .iDATA(s_data),
    .oREADY(s_ready), .iFHT_RDY(s_rdy), .oSTART(s_start), .oADDR_WR(s_addr),
    .oDATA_WR(s_wdata), .oWE(s_we), .oDONE(s_done), .oFRAME_CNT(s_fcnt)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int stb_cnt, start_cnt, done_cnt, onehot_err, overlap;
  int last_stb_cyc, start_cyc;
  int hits [1024];
  logic [15:0] got  [1024];
  logic [15:0] expd [1024];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned rev10(input int unsigned n);
    int unsigned r = 0;
    for (int i = 0; i < 10; i++) r |= ((n >> i) & 1) << (9 - i);
    return r;
  endfunction

  task automatic clear_stats();
    stb_cnt = 0; start_cnt = 0; done_cnt = 0; onehot_err = 0; overlap = 0;
    last_stb_cyc = -1; start_cyc = -1;
    for (int i = 0; i < 1024; i++) hits[i] = 0;
  endtask

  // Advance one clock and log what the main instance did in the new cycle.
  task automatic step();
    int b;
    @(posedge clk);
    #1;
    cyc++;
    if (we != 4'b0) begin
      b = 0;
      case (we)
        4'b0001: b = 0;
        4'b0010: b = 1;
        4'b0100: b = 2;
        4'b1000: b = 3;
        default: onehot_err++;
      endcase
      stb_cnt++;
      hits[b*256 + int'(addr)]++;
      got[b*256 + int'(addr)] = wdata;
      last_stb_cyc = cyc;
      if (start) overlap++;
    end
    if (start) begin start_cnt++; start_cyc = cyc; end
    if (done) done_cnt++;
  endtask

  initial begin
    int n, guard, bad_hits, bad_data, s_starts;
    logic seen;
    rst_n = 1'b1; clear = 0; valid = 0; rdy = 1; data = '0;
    s_clear = 0; s_valid = 0; s_rdy = 1; s_data = '0;
    clear_stats();
    #2 rst_n = 1'b0;
    step(); step(); step();
    check("rst_ready", ready, 0);
    check("rst_we", we, 0);
    check("rst_addr", addr, 0);
    check("rst_wdata", wdata, 0);
    check("rst_start_done", {start, done}, 0);
    check("rst_fcnt", fcnt, 0);

    // Release: one IDLE cycle, then LOAD.
    rst_n = 1'b1;
    #1;
    check("idle_ready", ready, 0);
    step();
    check("load_ready", ready, 1);
    check("load_outs", {we, start, done, fcnt}, 0);

    // Frame 1: contiguous samples, data = n.
    for (int i = 0; i < 1024; i++) begin
      valid = 1; data = 16'(i);
      step();
      if (i == 0)    check("n0",    {we, addr, wdata}, {4'b0001, 8'd0,   16'd0});
      if (i == 1)    check("n1",    {we, addr, wdata}, {4'b0100, 8'd0,   16'd1});
      if (i == 2)    check("n2",    {we, addr, wdata}, {4'b0010, 8'd0,   16'd2});
      if (i == 4)    check("n4",    {we, addr, wdata}, {4'b0001, 8'd128, 16'd4});
      if (i == 1023) check("n1023", {we, addr, wdata}, {4'b1000, 8'd255, 16'd1023});
    end
    valid = 0;
    check("last_ready", ready, 0);
    step();
    check("start_pulse", {start, we}, {1'b1, 4'b0});
    clear_stats();

    // Handshake: rdy high 5 cycles, low 2580, then high.
    rdy = 1;
    for (int i = 0; i < 5; i++) step();
    rdy = 0;
    for (int i = 0; i < 2580; i++) step();
    rdy = 1;
    step();
    check("hs_done", done, 1);
    check("hs_fcnt", fcnt, 1);
    check("hs_ready", ready, 1);
    step();
    check("hs_done_once", {done, 8'(done_cnt)}, {1'b0, 8'd1});
    check("hs_no_restart", start_cnt, 0);

    // Frame 2: random valid gaps, full scoreboard.
    clear_stats();
    n = 0; guard = 0;
    while (n < 1024 && guard < 20000) begin
      valid = 1'($urandom_range(0, 1));
      data = 16'($urandom);
      if (valid && ready) begin
        expd[rev10(n)] = data;
        n++;
      end
      step();
      guard++;
    end
    valid = 0;
    step(); step(); step();
    bad_hits = 0; bad_data = 0;
    for (int i = 0; i < 1024; i++) begin
      if (hits[i] != 1) bad_hits++;
      else if (got[i] !== expd[i]) bad_data++;
    end
    check("rnd_samples", n, 1024);
    check("rnd_strobes", stb_cnt, 1024);
    check("rnd_pairs_once", bad_hits, 0);
    check("rnd_data", bad_data, 0);
    check("rnd_onehot", onehot_err, 0);
    check("rnd_start_cnt", start_cnt, 1);
    check("rnd_start_pos", start_cyc, last_stb_cyc + 1);
    check("rnd_overlap", overlap, 0);
    rdy = 0; step();
    rdy = 1; step();
    check("rnd_fcnt", fcnt, 2);

    // Clear while sample 500 is offered.
    clear_stats();
    for (int i = 0; i < 500; i++) begin
      valid = 1; data = 16'(i);
      step();
    end
    valid = 0;
    step();
    clear = 1; valid = 1; data = 16'hABCD;
    step();
    clear = 0; valid = 0;
    check("clr_no_write", we, 0);
    check("clr_idle", ready, 0);
    check("clr_strobes", stb_cnt, 500);
    check("clr_fcnt_kept", fcnt, 2);
    step();
    check("clr_reload", ready, 1);
    valid = 1; data = 16'h1234;
    step();
    valid = 0;
    check("clr_restart", {we, addr, wdata}, {4'b0001, 8'd0, 16'h1234});

    // Reset mid-load clears everything, including the frame count.
    step(); step();
    rst_n = 0;
    #1;
    check("midrst_outs", {ready, we, addr, wdata, start, done, fcnt}, 0);
    step();
    rst_n = 1;
    step();
    check("midrst_ready", ready, 1);

    // 256 frames on the small instance; frame count wraps to zero.
    s_starts = 0;
    for (int f = 0; f < 256; f++) begin
      for (int i = 0; i < 16; i++) begin
        s_valid = 1; s_data = 16'(i);
        step();
      end
      s_valid = 0;
      seen = 0;
      for (int k = 0; k < 10 && !seen; k++) begin
        step();
        if (s_start) seen = 1;
      end
      if (seen) s_starts++;
      s_rdy = 0; step(); step();
      s_rdy = 1; step();
      if (f == 0)   check("wrap_f1", s_fcnt, 1);
      if (f == 254) check("wrap_f255", s_fcnt, 255);
    end
    check("wrap_starts", s_starts, 256);
    check("wrap_zero", s_fcnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fht_input_loader.md
FHT_INPUT_LOADER -- requirements
Module: fht_input_loader

Interface
REQ-001 Parameter A_BIT, default 8, per-bank address width; a frame is N = 4*2^A_BIT samples (1024 by default).
REQ-002 Parameter D_BIT, default 16, sample data width.
REQ-003 iCLK_2  in  1  clock; all state updates on its rising edge.
REQ-004 iRESET  in  1  reset, asynchronous, active-low.
REQ-005 iCLEAR  in  1  synchronous abort; returns the block to IDLE.
REQ-006 iVALID  in  1  input sample valid.
REQ-007 iDATA  in  D_BIT  input sample, natural time order.
REQ-008 oREADY  out  1  loader accepts a sample this cycle.
REQ-009 iFHT_RDY  in  1  transform-controller ready; high = idle or finished.
REQ-010 oSTART  out  1  one-cycle start pulse to the transform controller.
REQ-011 oADDR_WR  out  A_BIT  bank write address, common to all four banks.
REQ-012 oDATA_WR  out  D_BIT  bank write data.
REQ-013 oWE  out  4  one-hot bank write enable, bit k = bank k.
REQ-014 oDONE  out  1  one-cycle pulse when the controller completes a frame.
REQ-015 oFRAME_CNT  out  8  count of completed frames, wraps 255 -> 0.

Function
REQ-016 States: IDLE, LOAD, LAST, START, WAIT_BUSY, WAIT_DONE.
REQ-017 IDLE: oREADY=0; go to LOAD at the edge where iFHT_RDY=1.
REQ-018 LOAD: oREADY=1.
- A sample is accepted when iVALID=1 and oREADY=1; the 10-bit (A_BIT+2) sample counter n then increments.
- iVALID=0 cycles stall the load with no write.
REQ-019 For an accepted sample n, r = bit-reverse of n over A_BIT+2 bits; bank = r[A_BIT+1:A_BIT]; address = r[A_BIT-1:0].
REQ-020 Write outputs are registered with 1-cycle latency.
- In the cycle after acceptance: oWE has exactly one bit set (the selected bank), oADDR_WR = address, oDATA_WR = sample.
- In every other cycle, oWE = 0; oADDR_WR and oDATA_WR hold their last values.
REQ-021 On acceptance of sample N-1: the counter wraps to 0 and the state goes to LAST; oREADY=0 from the next cycle.
REQ-022 LAST lasts exactly one cycle (the final write strobe is issued in it), then the state goes to START.
REQ-023 START: oSTART=1 for exactly this one cycle, then WAIT_BUSY; oSTART is therefore never coincident with any oWE bit.
REQ-024 WAIT_BUSY: go to WAIT_DONE at the edge where iFHT_RDY=0.
REQ-025 WAIT_DONE: go to LOAD at the edge where iFHT_RDY=1; oDONE=1 in the following cycle only, and oFRAME_CNT increments on that same edge.
REQ-026 oREADY=0 in every state except LOAD.
REQ-027 iCLEAR=1 in any state:
- next state is IDLE; sample counter = 0; oWE = 0; oSTART = 0; oDONE = 0.
- oFRAME_CNT is kept.
- a sample offered in that cycle is not accepted.
- iCLEAR has priority over all transitions.
REQ-028 iFHT_RDY=1 during WAIT_BUSY keeps the loader in WAIT_BUSY indefinitely; no re-pulse of oSTART.
REQ-029 A frame is never partially restarted; only iCLEAR or reset discard a partial load.

Reset
REQ-030 While iRESET=0 the following hold:
- state = IDLE; sample counter = 0.
- oREADY = 0, oWE = 0, oADDR_WR = 0, oDATA_WR = 0.
- oSTART = 0, oDONE = 0, oFRAME_CNT = 0.
REQ-031 Reset assertion mid-load discards the partial frame; after release, behaviour is as from power-up.

Verification
REQ-032 Reset release, iFHT_RDY=1 -> IDLE for one cycle, then oREADY=1; all other outputs 0.
REQ-033 Samples n=0,1,2,4,1023 with data = n:
- n=0 -> oWE=0001, addr 0.
- n=1 -> oWE=0100, addr 0.
- n=2 -> oWE=0010, addr 0.
- n=4 -> oWE=0001, addr 128.
- n=1023 -> oWE=1000, addr 255.
- each strobe appears one cycle after acceptance.
REQ-034 Full frame with random iVALID gaps -> exactly 1024 oWE strobes; every (bank, address) pair is written exactly once; oSTART is 1 cycle wide, one cycle after the last strobe.
REQ-035 Handshake sequence: after oSTART, hold iFHT_RDY=1 for 5 cycles, then 0 for 2580 cycles, then 1 ->
- no second oSTART;
- oDONE pulses once and oFRAME_CNT = 1;
- oREADY=1 again.
REQ-036 iCLEAR at sample 500 with iVALID=1 -> that sample is not written; IDLE; the next frame restarts at n=0 (bank 0, addr 0).
REQ-037 Run 256 frames -> oFRAME_CNT wraps to 0.
